hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Next-generation pipeline hazard unit for the 5-stage MIPS core.
- Replaces the purely combinational branch/jump flush decode with a clocked controller that provides:
  - multi-cycle flush for deeper fetch front-ends;
  - load-use stall detection;
  - EX-stage operand forwarding selects;
  - a busy interlock for the multi-cycle mult/div unit.
- Sits beside the datapath and drives the IF/ID/EX pipeline-register enables and clears.

Parameters:
- REG_AW, 5: register address width.
- FLUSH_DEPTH, 1: cycles flush is held after a taken branch/jump (1..7).
- MD_LAT, 4: mult/div latency in cycles (2..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- branch_jump  in  2  EX-stage redirect code; 0 = none, 1/2/3 = branch taken / jump / jump-register.
- id_rs, id_rt  in  REG_AW  source registers of the ID instruction.
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs/rt.
- id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo) or is itself mult/div.
- ex_rs, ex_rt  in  REG_AW  source registers of the EX instruction.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_memread  in  1  EX instruction is a load.
- ex_md_start  in  1  EX instruction issues mult/div this cycle.
- mem_rd  in  REG_AW  MEM destination register.
- mem_regwrite  in  1  MEM instruction writes the register file.
- wb_rd  in  REG_AW  WB destination register.
- wb_regwrite  in  1  WB instruction writes the register file.
- stall  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- flush  out  1  clear IF/ID and ID/EX.
- fwd_a, fwd_b  out  2  EX operand select; 00 = regfile, 10 = MEM, 01 = WB.
- md_busy  out  1  mult/div in progress.

Behaviour:
- Reset (rst_n = 0 at posedge): flush counter = 0, MD FSM = IDLE, MD counter = 0. While rst_n = 0, all outputs are forced to 0.
- Forwarding (combinational, 0-cycle):
  - fwd_a = 10 if mem_regwrite && mem_rd != 0 && mem_rd == ex_rs.
  - Otherwise fwd_a = 01 if wb_regwrite && wb_rd != 0 && wb_rd == ex_rs.
  - Otherwise fwd_a = 00. fwd_b is identical using ex_rt.
  - MEM has priority over WB. Register 0 is never forwarded.
- Load-use hazard (lu): ex_memread && ex_rd != 0 && ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt)).
- Flush:
  - flush = (branch_jump != 0) || (fcnt != 0), combinational.
  - On a posedge with branch_jump != 0, fcnt loads FLUSH_DEPTH-1. Otherwise, if fcnt != 0, fcnt decrements.
  - A new redirect during an active count reloads the count (no accumulation).
  - With FLUSH_DEPTH = 1, flush equals the legacy (branch_jump != 0) decode.
- MD FSM, states IDLE and BUSY:
  - IDLE -> BUSY on ex_md_start; mcnt loads MD_LAT-1.
  - In BUSY, mcnt decrements each cycle; BUSY -> IDLE on the posedge where mcnt == 0.
  - md_busy = (state == BUSY).
  - An ex_md_start arriving while BUSY is illegal, because the ID interlock prevents it.
  - Flush does not cancel an issued mult/div (it is already past EX).
- Stall logic:
  - mdh = md_busy && id_uses_hilo.
  - stall = (lu || mdh) && !flush.
  - bubble_ex = stall.
  - flush has priority over stall: the stalled instruction is wrong-path.
- Simultaneous redirect + load-use: flush = 1, stall = 0.
- Reset mid-operation: FSM and counters are abandoned; outputs are 0 from the cycle after the reset edge until rst_n = 1.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles[15:0] and flush_events[15:0].
  - stall_cycles increments on every cycle with stall = 1.
  - flush_events increments on every cycle with branch_jump != 0.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Not defined: the ports still exist and are tied to 16'h0; no counter logic is synthesised.

Test Plan:
- Forwarding: ex_rs = 3, mem_rd = 3, mem_regwrite = 1, wb_rd = 3, wb_regwrite = 1 -> fwd_a = 10. Then clear mem_regwrite -> fwd_a = 01. Then ex_rs = 0 with mem_rd = 0 -> fwd_a = 00.
- Load-use: ex_memread = 1, ex_rd = 8, id_rs = 8, id_uses_rs = 1 -> stall = bubble_ex = 1 for exactly that cycle; repeat with id_uses_rs = 0 -> stall = 0.
- Flush depth: FLUSH_DEPTH = 3, branch_jump = 2 for one cycle -> flush high for 3 cycles. A second branch on cycle 2 -> flush stays high through cycle 4.
- MD interlock: MD_LAT = 4, ex_md_start pulse -> md_busy high for 4 cycles. id_uses_hilo = 1 during that window -> stall = 1 for those 4 cycles, then 0.
- Priority and reset: branch_jump = 1 together with a load-use condition -> flush = 1, stall = 0. Assert rst_n = 0 mid-BUSY -> md_busy = 0 after the next edge; with HAZARD_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/hazard_if.sv
// Bundle of hazard-unit signals between the datapath (master) and hazard_ctrl (slave).
// The stats outputs are always present; they read zero unless HAZARD_STATS_EN is defined.
interface hazard_if #(
  parameter int REG_AW = 5
);
  logic [1:0]        branch_jump;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_uses_hilo;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_md_start;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;

  logic              stall;
  logic              bubble_ex;
  logic              flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              md_busy;
  logic [15:0]       stall_cycles;
  logic [15:0]       flush_events;

  modport master (
    output branch_jump, id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
           ex_rs, ex_rt, ex_rd, ex_memread, ex_md_start,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  stall, bubble_ex, flush, fwd_a, fwd_b, md_busy,
           stall_cycles, flush_events
  );

  modport slave (
    input  branch_jump, id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
           ex_rs, ex_rt, ex_rd, ex_memread, ex_md_start,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output stall, bubble_ex, flush, fwd_a, fwd_b, md_busy,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Clocked hazard unit for the 5-stage MIPS core: forwarding, load-use stall, multi-cycle flush,
// mult/div busy interlock. Optional stall/flush statistics counters under macro HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int MD_LAT      = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  localparam logic [REG_AW-1:0] REG_ZERO   = '0;
  localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [3:0]        MD_LOAD    = 4'(MD_LAT - 1);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e  md_state_q, md_state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [2:0] fcnt_q, fcnt_d;

  logic       redirect;
  logic       flush_raw;
  logic       lu;
  logic       md_busy_raw;
  logic       stall_raw;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // MEM beats WB so the youngest producer wins; r0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_dst,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_dst
  );
    if (mem_we && mem_dst != REG_ZERO && mem_dst == src) return 2'b10;
    if (wb_we && wb_dst != REG_ZERO && wb_dst == src)    return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a_raw = fwd_sel(hz.ex_rs, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
  assign fwd_b_raw = fwd_sel(hz.ex_rt, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);

  assign redirect = (hz.branch_jump != 2'd0);
  assign lu = hz.ex_memread && (hz.ex_rd != REG_ZERO) &&
              ((hz.id_uses_rs && hz.ex_rd == hz.id_rs) ||
               (hz.id_uses_rt && hz.ex_rd == hz.id_rt));

  assign flush_raw   = redirect || (fcnt_q != 3'd0);
  assign md_busy_raw = (md_state_q == MD_BUSY);
  // A stalled instruction under flush is wrong-path, so flush wins.
  assign stall_raw   = (lu || (md_busy_raw && hz.id_uses_hilo)) && !flush_raw;

  // NOTE: every signal assigned in always_comb gets a default first; otherwise a missed
  // branch leaves it holding its old value and synthesis infers a latch.
  always_comb begin
    fcnt_d = fcnt_q;
    if (redirect) begin
      fcnt_d = FLUSH_LOAD;
    end else if (fcnt_q != 3'd0) begin
      fcnt_d = fcnt_q - 3'd1;
    end
  end

  always_comb begin
    md_state_d = md_state_q;
    mcnt_d     = mcnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (hz.ex_md_start) begin
          md_state_d = MD_BUSY;
          mcnt_d     = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (mcnt_q == 4'd0) begin
          md_state_d = MD_IDLE;
        end else begin
          mcnt_d = mcnt_q - 4'd1;
        end
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q     <= 3'd0;
      mcnt_q     <= 4'd0;
      md_state_q <= MD_IDLE;
    end else begin
      fcnt_q     <= fcnt_d;
      mcnt_q     <= mcnt_d;
      md_state_q <= md_state_d;
    end
  end

  // Outputs are held low for as long as reset is asserted.
  assign hz.flush     = rst_n & flush_raw;
  assign hz.stall     = rst_n & stall_raw;
  assign hz.bubble_ex = rst_n & stall_raw;
  assign hz.md_busy   = rst_n & md_busy_raw;
  assign hz.fwd_a     = rst_n ? fwd_a_raw : 2'b00;
  assign hz.fwd_b     = rst_n ? fwd_b_raw : 2'b00;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_raw && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (redirect && flush_cnt_q != 16'hFFFF)  flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cycles = rst_n ? stall_cnt_q : 16'd0;
  assign hz.flush_events = rst_n ? flush_cnt_q : 16'd0;
`else
  assign hz.stall_cycles = 16'd0;
  assign hz.flush_events = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (FLUSH_DEPTH=3, MD_LAT=4); expectations go into a queue
// that a negedge monitor drains and compares against the DUT outputs.
module tb_hazard_ctrl;

  logic clk = 1'b1;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_if #(.REG_AW(5)) hz_if ();

  hazard_ctrl #(
    .REG_AW     (5),
    .FLUSH_DEPTH(3),
    .MD_LAT     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz_if)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        md;
    logic [15:0] sc;
    logic [15:0] fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_stall  = 0;
  int   n_bj     = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are already driven; push the expected outputs for this cycle, then advance.
  task automatic cyc(input string name, input logic e_st, input logic e_fl,
                     input logic [1:0] e_fa, input logic [1:0] e_fb, input logic e_md);
    exp_t e;
    e.name  = name;
    e.stall = e_st;
    e.flush = e_fl;
    e.fa    = e_fa;
    e.fb    = e_fb;
    e.md    = e_md;
`ifdef HAZARD_STATS_EN
    e.sc = rst_n ? 16'(n_stall) : 16'd0;
    e.fe = rst_n ? 16'(n_bj)    : 16'd0;
`else
    e.sc = 16'd0;
    e.fe = 16'd0;
`endif
    if (rst_n) begin
      if (e_st) n_stall++;
      if (hz_if.branch_jump != 2'd0) n_bj++;
    end else begin
      n_stall = 0;
      n_bj    = 0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz_if.branch_jump  = 2'd0;
    hz_if.id_rs        = '0;
    hz_if.id_rt        = '0;
    hz_if.id_uses_rs   = 1'b0;
    hz_if.id_uses_rt   = 1'b0;
    hz_if.id_uses_hilo = 1'b0;
    hz_if.ex_rs        = '0;
    hz_if.ex_rt        = '0;
    hz_if.ex_rd        = '0;
    hz_if.ex_memread   = 1'b0;
    hz_if.ex_md_start  = 1'b0;
    hz_if.mem_rd       = '0;
    hz_if.mem_regwrite = 1'b0;
    hz_if.wb_rd        = '0;
    hz_if.wb_regwrite  = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.name, ".stall"},     16'(hz_if.stall),     16'(e.stall));
        check({e.name, ".bubble_ex"}, 16'(hz_if.bubble_ex), 16'(e.stall));
        check({e.name, ".flush"},     16'(hz_if.flush),     16'(e.flush));
        check({e.name, ".fwd_a"},     16'(hz_if.fwd_a),     16'(e.fa));
        check({e.name, ".fwd_b"},     16'(hz_if.fwd_b),     16'(e.fb));
        check({e.name, ".md_busy"},   16'(hz_if.md_busy),   16'(e.md));
        check({e.name, ".stall_cycles"}, hz_if.stall_cycles, e.sc);
        check({e.name, ".flush_events"}, hz_if.flush_events, e.fe);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    clr();
    cyc("rst0", 0, 0, 2'b00, 2'b00, 0);
    cyc("rst1", 0, 0, 2'b00, 2'b00, 0);
    rst_n = 1'b1;
    cyc("idle", 0, 0, 2'b00, 2'b00, 0);

    // Forwarding
    hz_if.ex_rs = 5'd3; hz_if.ex_rt = 5'd5;
    hz_if.mem_rd = 5'd3; hz_if.mem_regwrite = 1'b1;
    hz_if.wb_rd = 5'd3;  hz_if.wb_regwrite = 1'b1;
    cyc("fwd_mem", 0, 0, 2'b10, 2'b00, 0);
    hz_if.mem_regwrite = 1'b0;
    cyc("fwd_wb", 0, 0, 2'b01, 2'b00, 0);
    hz_if.ex_rs = 5'd0; hz_if.mem_rd = 5'd0; hz_if.mem_regwrite = 1'b1; hz_if.wb_rd = 5'd0;
    cyc("fwd_r0", 0, 0, 2'b00, 2'b00, 0);
    hz_if.ex_rs = 5'd4; hz_if.ex_rt = 5'd6; hz_if.mem_rd = 5'd4; hz_if.wb_rd = 5'd6;
    cyc("fwd_split", 0, 0, 2'b10, 2'b01, 0);
    hz_if.mem_rd = 5'd6;
    cyc("fwd_b_mem", 0, 0, 2'b00, 2'b10, 0);
    clr();

    // Load-use
    hz_if.ex_memread = 1'b1; hz_if.ex_rd = 5'd8; hz_if.id_rs = 5'd8; hz_if.id_uses_rs = 1'b1;
    cyc("lu_rs", 1, 0, 2'b00, 2'b00, 0);
    hz_if.ex_memread = 1'b0;
    cyc("lu_gone", 0, 0, 2'b00, 2'b00, 0);
    hz_if.ex_memread = 1'b1; hz_if.id_uses_rs = 1'b0;
    cyc("lu_nouse", 0, 0, 2'b00, 2'b00, 0);
    hz_if.id_rt = 5'd8; hz_if.id_uses_rt = 1'b1;
    cyc("lu_rt", 1, 0, 2'b00, 2'b00, 0);
    hz_if.ex_rd = 5'd0; hz_if.id_rs = 5'd0; hz_if.id_rt = 5'd0; hz_if.id_uses_rs = 1'b1;
    cyc("lu_r0", 0, 0, 2'b00, 2'b00, 0);
    clr();

    // Flush depth 3, then a reload during an active count
    hz_if.branch_jump = 2'd2;
    cyc("br", 0, 1, 2'b00, 2'b00, 0);
    hz_if.branch_jump = 2'd0;
    cyc("br_h1", 0, 1, 2'b00, 2'b00, 0);
    cyc("br_h2", 0, 1, 2'b00, 2'b00, 0);
    cyc("br_end", 0, 0, 2'b00, 2'b00, 0);
    hz_if.branch_jump = 2'd2;
    cyc("br2_c0", 0, 1, 2'b00, 2'b00, 0);
    hz_if.branch_jump = 2'd0;
    cyc("br2_c1", 0, 1, 2'b00, 2'b00, 0);
    hz_if.branch_jump = 2'd1;
    cyc("br2_c2", 0, 1, 2'b00, 2'b00, 0);
    hz_if.branch_jump = 2'd0;
    cyc("br2_c3", 0, 1, 2'b00, 2'b00, 0);
    cyc("br2_c4", 0, 1, 2'b00, 2'b00, 0);
    cyc("br2_c5", 0, 0, 2'b00, 2'b00, 0);

    // Mult/div interlock
    hz_if.ex_md_start = 1'b1;
    cyc("md_start", 0, 0, 2'b00, 2'b00, 0);
    hz_if.ex_md_start = 1'b0; hz_if.id_uses_hilo = 1'b1;
    cyc("md_b1", 1, 0, 2'b00, 2'b00, 1);
    cyc("md_b2", 1, 0, 2'b00, 2'b00, 1);
    cyc("md_b3", 1, 0, 2'b00, 2'b00, 1);
    cyc("md_b4", 1, 0, 2'b00, 2'b00, 1);
    cyc("md_done", 0, 0, 2'b00, 2'b00, 0);
    clr();

    // Redirect beats load-use, including the held flush cycles
    hz_if.branch_jump = 2'd1;
    hz_if.ex_memread = 1'b1; hz_if.ex_rd = 5'd9; hz_if.id_rs = 5'd9; hz_if.id_uses_rs = 1'b1;
    cyc("prio", 0, 1, 2'b00, 2'b00, 0);
    hz_if.branch_jump = 2'd0;
    cyc("prio_h1", 0, 1, 2'b00, 2'b00, 0);
    cyc("prio_h2", 0, 1, 2'b00, 2'b00, 0);
    cyc("prio_stall", 1, 0, 2'b00, 2'b00, 0);
    clr();
    cyc("quiet", 0, 0, 2'b00, 2'b00, 0);

    // Reset in the middle of a busy mult/div
    hz_if.ex_md_start = 1'b1;
    cyc("md2_start", 0, 0, 2'b00, 2'b00, 0);
    hz_if.ex_md_start = 1'b0;
    cyc("md2_busy", 0, 0, 2'b00, 2'b00, 1);
    rst_n = 1'b0;
    hz_if.mem_rd = 5'd2; hz_if.mem_regwrite = 1'b1; hz_if.ex_rs = 5'd2;
    cyc("rst_mid", 0, 0, 2'b00, 2'b00, 0);
    rst_n = 1'b1;
    clr();
    cyc("post_rst", 0, 0, 2'b00, 2'b00, 0);
    cyc("post_rst2", 0, 0, 2'b00, 2'b00, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
